// File: rtl/counter_stim_gen_pkg.sv
// Shared definitions for the 4-bit counter stimulus generator, the counter and its checker:
// FSM state/phase encodings, counter mode constants and the LFSR feedback tap.
package counter_stim_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_UP    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_DOWN3 = 3'd4,
    ST_LOAD  = 3'd5,
    ST_DIS   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Shift left, feedback from bits 3 and 2; maximal length, so a nonzero seed never reaches 0.
  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

endpackage

// File: rtl/counter_stim_gen_lfsr4.sv
// 4-bit Fibonacci LFSR that advances only when step is high; reloads SEED on reset.
module lfsr4
  import counter_stim_gen_pkg::*;
#(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [3:0] value
);

  logic [3:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= SEED;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_stim_gen.sv
// Stimulus sequencer for a 4-bit up/down/down3/load counter: walks RST, UP, DOWN, DOWN3, LOAD, DIS, DONE
// with fully registered outputs, optionally looping back to RST at the end of each sequence.
module counter_stim_gen
  import counter_stim_gen_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 8,
  parameter int unsigned RST_LEN   = 2,
  parameter logic [3:0]  SEED      = 4'b1001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       loop,
  output logic       reset_dut,
  output logic       enable_,
  output logic [3:0] D,
  output logic [1:0] mode,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PHASE_LAST = 8'(PHASE_LEN - 1);
  localparam logic [7:0] RST_LAST   = 8'(RST_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_cnt;
  logic [3:0] lfsr_val;
  logic       lfsr_step;

  logic       reset_dut_q, reset_dut_d;
  logic       enable_q, enable_d;
  logic [3:0] d_q, d_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] phase_q, phase_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  assign lfsr_step = (state_q == ST_LOAD);

  lfsr4 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // State and phase counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns each variable and no latch is inferred.
    state_d  = state_q;
    last_cnt = (state_q == ST_RST) ? (cnt_q == RST_LAST) : (cnt_q == PHASE_LAST);
    unique case (state_q)
      ST_IDLE:  if (start)    state_d = ST_RST;
      ST_RST:   if (last_cnt) state_d = ST_UP;
      ST_UP:    if (last_cnt) state_d = ST_DOWN;
      ST_DOWN:  if (last_cnt) state_d = ST_DOWN3;
      ST_DOWN3: if (last_cnt) state_d = ST_LOAD;
      ST_LOAD:  if (last_cnt) state_d = ST_DIS;
      ST_DIS:   if (last_cnt) state_d = ST_DONE;
      ST_DONE:  state_d = loop ? ST_RST : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == ST_IDLE) ? 8'd0 : cnt_q + 8'd1;
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    reset_dut_d = (state_d == ST_RST);
    enable_d    = 1'b0;
    mode_d      = MODE_UP;
    phase_d     = state_d;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    d_d         = d_q;
    unique case (state_d)
      ST_UP:    enable_d = 1'b1;
      ST_DOWN:  begin enable_d = 1'b1; mode_d = MODE_DOWN;  end
      ST_DOWN3: begin enable_d = 1'b1; mode_d = MODE_DOWN3; end
      ST_LOAD:  begin enable_d = 1'b1; mode_d = MODE_LOAD;  end
      default:  ;
    endcase
    // While already in LOAD the LFSR steps on this edge, so D must pick up the stepped value.
    if (state_d == ST_LOAD) begin
      d_d = (state_q == ST_LOAD) ? lfsr_next(lfsr_val) : lfsr_val;
    end else if (state_d == ST_IDLE) begin
      d_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reset_dut_q <= 1'b0;
      enable_q    <= 1'b0;
      d_q         <= 4'd0;
      mode_q      <= MODE_UP;
      phase_q     <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reset_dut_q <= reset_dut_d;
      enable_q    <= enable_d;
      d_q         <= d_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign reset_dut = reset_dut_q;
  assign enable_   = enable_q;
  assign D         = d_q;
  assign mode      = mode_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_stim_gen.sv
// Directed bench for counter_stim_gen: cycle-exact sequence timing, LFSR load data, looping,
// mid-sequence reset and a reference 4-bit counter driven by the generated stimulus.
module tb_counter_stim_gen;

  logic       clk = 1'b0;
  logic       reset, start, loop;
  logic       reset_dut, enable_, busy, done;
  logic [3:0] D;
  logic [1:0] mode;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] load_d1 [8] = '{4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
  logic [3:0] ref_cnt;

  counter_stim_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .loop      (loop),
    .reset_dut (reset_dut),
    .enable_   (enable_),
    .D         (D),
    .mode      (mode),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference counter fed by the generator outputs.
  always @(posedge clk) begin
    if (reset_dut) ref_cnt <= 4'd0;
    else if (enable_) begin
      case (mode)
        2'b00: ref_cnt <= ref_cnt + 4'd1;
        2'b01: ref_cnt <= ref_cnt - 4'd1;
        2'b10: ref_cnt <= ref_cnt - 4'd3;
        2'b11: ref_cnt <= D;
        default: ref_cnt <= ref_cnt;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; start = 1'b0; loop = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [8:0] act_vec();
    return {phase, reset_dut, enable_, mode, busy, done};
  endfunction

  // Expected {phase, reset_dut, enable_, mode, busy, done} for cycle i counted from RST entry.
  function automatic logic [8:0] exp_vec(int i);
    if (i < 2)  return {3'd1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    if (i < 10) return {3'd2, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
    if (i < 18) return {3'd3, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
    if (i < 26) return {3'd4, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0};
    if (i < 34) return {3'd5, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    if (i < 42) return {3'd6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    return {3'd7, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
  endfunction

  function automatic logic [3:0] exp_d(int i);
    if (i < 26) return 4'd0;
    if (i < 34) return load_d1[i-26];
    return 4'h7;
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; loop = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({act_vec(), D} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", {act_vec(), D}, 13'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({act_vec(), D} !== 13'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset[%0d]: got %h expected %h", k, {act_vec(), D}, 13'd0);
      end
    end
  endtask

  task automatic test_full_sequence(input bit poke_start);
    int bad_cycles = 0;
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 43; i++) begin
      n_cmp++;
      if (act_vec() !== exp_vec(i) || D !== exp_d(i)) begin
        n_bad++;
        bad_cycles++;
        $display("FAIL seq%0d_cycle%0d: got vec=%h D=%h expected vec=%h D=%h",
                 poke_start, i, act_vec(), D, exp_vec(i), exp_d(i));
      end
      start = (poke_start && i == 4);
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if ({act_vec(), D} !== 13'd0) begin
      n_bad++;
      $display("FAIL seq%0d_back_to_idle: got %h expected %h", poke_start, {act_vec(), D}, 13'd0);
    end
  endtask

  task automatic test_loop;
    apply_reset();
    loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (42) tick();
    n_cmp++;
    if (phase !== 3'd7 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL loop_done: got phase=%0d done=%b expected phase=7 done=1", phase, done);
    end
    tick();
    n_cmp++;
    if (phase !== 3'd1 || reset_dut !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL loop_rst_reentry: got phase=%0d reset_dut=%b done=%b expected phase=1 reset_dut=1 done=0",
               phase, reset_dut, done);
    end
    repeat (26) tick();
    n_cmp++;
    if (phase !== 3'd5 || D !== 4'hF) begin
      n_bad++;
      $display("FAIL loop_first_load_d: got phase=%0d D=%h expected phase=5 D=f", phase, D);
    end
    loop = 1'b0;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    n_cmp++;
    if (phase !== 3'd4 || mode !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_in_down3: got phase=%0d mode=%b expected phase=4 mode=10", phase, mode);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({act_vec(), D} !== 13'd0) begin
      n_bad++;
      $display("FAIL mid_async_abort: got %h expected %h", {act_vec(), D}, 13'd0);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({act_vec(), D} !== 13'd0) begin
        n_bad++;
        $display("FAIL mid_idle_wait[%0d]: got %h expected %h", k, {act_vec(), D}, 13'd0);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (phase !== 3'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_restart: got phase=%0d busy=%b expected phase=1 busy=1", phase, busy);
    end
  endtask

  task automatic test_ref_counter;
    logic [3:0] exp_cnt [3] = '{4'd7, 4'd9, 4'd15};
    apply_reset();
    loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      int  len = 1;
      bit  found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
        if (done) found = 1'b1;
        else begin
          tick();
          len++;
        end
      end
      n_cmp++;
      if (!found) begin
        n_bad++;
        $display("FAIL ref_pass%0d_timeout: got no done pulse expected done within 60 cycles", p);
      end else if (len !== 43 || ref_cnt !== exp_cnt[p]) begin
        n_bad++;
        $display("FAIL ref_pass%0d: got len=%0d count=%0d expected len=43 count=%0d",
                 p, len, ref_cnt, exp_cnt[p]);
      end
      tick();
      if (p == 1) loop = 1'b0;
      n_cmp++;
      if (phase !== ((p < 2) ? 3'd1 : 3'd0)) begin
        n_bad++;
        $display("FAIL ref_pass%0d_next: got phase=%0d expected %0d", p, phase, (p < 2) ? 1 : 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; loop = 1'b0;
    test_reset();
    test_full_sequence(1'b0);
    test_full_sequence(1'b1);
    test_loop();
    test_reset_mid();
    test_ref_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_stim_gen.md
COUNTER_STIM_GEN -- requirements
Module: counter_stim_gen

Interface
REQ-001 Parameter PHASE_LEN, default 8, SHALL set the number of cycles spent in each counting phase (legal range 1..255).
REQ-002 Parameter RST_LEN, default 2, SHALL set the number of cycles reset_dut is held high (legal range 1..15).
REQ-003 Parameter SEED, default 4'b1001, SHALL set the nonzero LFSR value loaded at reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset of this block.
REQ-006 start  input  1  one-cycle request to begin a stimulus sequence; sampled only in IDLE.
REQ-007 loop  input  1  when high at sequence end, the sequence SHALL restart instead of returning to IDLE.
REQ-008 reset_dut  output  1  active-high reset driven to the 4-bit counter and its checker.
REQ-009 enable_  output  1  counter enable driven to the counter and its checker.
REQ-010 D  output  4  load data for mode 2'b11.
REQ-011 mode  output  2  counter mode: 00 up, 01 down, 10 down-by-3, 11 load.
REQ-012 phase  output  3  encoding of the current FSM state.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 FSM states and phase encoding SHALL be IDLE=0, RST=1, UP=2, DOWN=3, DOWN3=4, LOAD=5, DIS=6, DONE=7.
REQ-017 IDLE: reset_dut=0, enable_=0, mode=00, D=0; start=1 SHALL move to RST on the next edge.
REQ-018 RST: reset_dut=1, enable_=0 for exactly RST_LEN cycles, then UP.
REQ-019 UP: reset_dut=0, enable_=1, mode=00 for exactly PHASE_LEN cycles, then DOWN.
REQ-020 DOWN: enable_=1, mode=01 for PHASE_LEN cycles, then DOWN3.
REQ-021 DOWN3: enable_=1, mode=10 for PHASE_LEN cycles, then LOAD.
REQ-022 LOAD: enable_=1, mode=11 for PHASE_LEN cycles; D SHALL equal the current LFSR value, and the LFSR SHALL advance once per LOAD cycle.
REQ-023 DIS: enable_=0, mode=00 for PHASE_LEN cycles, then DONE.
REQ-024 DONE: one cycle, done=1, enable_=0; next state RST if loop=1, otherwise IDLE.
REQ-025 The LFSR SHALL be 4 bits with next = {lfsr[2:0], lfsr[3]^lfsr[2]}; it SHALL never reach 0 and SHALL continue from its last value (not reseed) across looped sequences.
REQ-026 An 8-bit phase counter SHALL reset to 0 on every state entry; the exit transition SHALL occur when count == length-1.
REQ-027 start asserted outside IDLE SHALL be ignored; start and loop are not latched.
REQ-028 busy SHALL be high from the first RST cycle through the DONE cycle inclusive.
REQ-029 D SHALL hold its last LOAD value outside LOAD until the next IDLE, where it SHALL be 0.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE, counter=0, LFSR=SEED, reset_dut=0, enable_=0, mode=00, D=0, phase=0, busy=0, done=0.
REQ-031 reset asserted mid-sequence SHALL abort immediately; after release, the block SHALL wait in IDLE for a new start.

Structure
REQ-032 State encodings, mode constants (MODE_UP, MODE_DOWN, MODE_DOWN3, MODE_LOAD) and LFSR tap definition SHALL reside in the shared counter package used by the counter and checker.
REQ-033 The LFSR SHALL be a separate sub-module named lfsr4 (inputs clk, reset, step; output value).

Verification
REQ-034 reset release, start pulse, default parameters -> reset_dut=1 for 2 cycles, then mode 00/01/10/11 for 8 cycles each, enable_=0 for 8 cycles, done pulse; total 43 cycles from RST entry to DONE inclusive.
REQ-035 LOAD phase with SEED=1001 -> D sequence 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111.
REQ-036 loop=1 at DONE -> RST re-entered next cycle; first LOAD D of second pass = 1111 (LFSR continued, not reseeded).
REQ-037 start pulsed during UP -> no effect; sequence timing identical to REQ-034.
REQ-038 reset asserted during DOWN3 -> all outputs 0 in the same cycle; state IDLE; after release, outputs stay idle until start.
REQ-039 Self-check: drive a reference 4-bit counter and its checker with the outputs -> zero mismatches over 3 looped sequences.
